// File: rtl/dec38_pkg.sv
// Shared types and constants for the registered 3:8 decoder pipeline.
package dec38_pkg;
    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    localparam logic [ONEHOT_W-1:0] INACTIVE_LO = 8'h00;
    localparam logic [ONEHOT_W-1:0] INACTIVE_HI = 8'hFF;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;
endpackage

// File: rtl/dec38_skid_buf.sv
// Two-entry valid/ready skid buffer: entry 0 is the output register, entry 1 the skid slot.
// Latency 1 cycle from in_fire to out_vld; full_o asserts the cycle after the second word lands.
// Backpressure: caller must gate in_fire_i with !full_o; words drain in FIFO order on out_rdy_i.
module dec38_skid_buf
    import dec38_pkg::*;
#(
    parameter int DAT_W = ONEHOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_fire_i,
    input  logic [DAT_W-1:0] in_dat_i,
    input  logic             out_rdy_i,
    output logic             out_vld_o,
    output logic [DAT_W-1:0] out_dat_o,
    output logic             full_o
);
    skid_state_e      state_q, state_d;
    logic [DAT_W-1:0] ent0_q, ent0_d;
    logic [DAT_W-1:0] ent1_q, ent1_d;
    logic             out_fire;

    assign out_fire = (state_q != EMPTY) && out_rdy_i;

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            EMPTY: begin
                if (in_fire_i) begin
                    ent0_d  = in_dat_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire_i && out_fire) begin
                    ent0_d = in_dat_i;
                end else if (in_fire_i) begin
                    ent1_d  = in_dat_i;
                    state_d = FULL;
                end else if (out_fire) begin
                    // Clearing entry 0 returns the output to the inactive pattern.
                    ent0_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    ent0_d  = ent1_q;
                    state_d = ONE;
                end
            end
            default: begin
                ent0_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            state_q <= state_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign out_vld_o = (state_q != EMPTY);
    assign out_dat_o = ent0_q;
    assign full_o    = (state_q == FULL);
endmodule

// File: rtl/encoder83_mux.sv
// 8:3 priority encoder built from a mux_2x1 chain; highest set line wins.
// Combinational. Only compiled when DEC_ROUNDTRIP_CHECK_EN is defined.
`ifdef DEC_ROUNDTRIP_CHECK_EN
module encoder83_mux
    import dec38_pkg::*;
(
    input  onehot_t onehot_i,
    output code_t   code_o
);
    logic [ONEHOT_W:0][CODE_W-1:0] st;

    assign st[0] = '0;

    // Each stage overrides the running code when its line is set.
    for (genvar k = 0; k < ONEHOT_W; k++) begin : g_stage
        localparam code_t KC = code_t'(k);
        for (genvar b = 0; b < CODE_W; b++) begin : g_bit
            mux_2x1 u_mux (
                .a_i   (st[k][b]),
                .b_i   (KC[b]),
                .sel_i (onehot_i[k]),
                .y_o   (st[k+1][b])
            );
        end
    end

    assign code_o = st[ONEHOT_W];
endmodule
`endif

// File: rtl/mux_2x1.sv
// Single-bit 2:1 multiplexer primitive: sel=0 passes a, sel=1 passes b.
// Combinational, no storage, no flow control.
module mux_2x1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/decoder38_mux_pipe.sv
// Registered 3:8 one-hot decoder (mux_2x1 tree) with valid/ready on both sides; 1-cycle latency.
// Backpressure: 2-entry skid keeps full throughput; in_ready = en & !rst & !full.
// Optional round-trip self-check via macro DEC_ROUNDTRIP_CHECK_EN drives the sticky err flag.
module decoder38_mux_pipe
    import dec38_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_y,
    output logic       err
);
    localparam onehot_t POL_MASK = ACTIVE_LOW ? INACTIVE_HI : INACTIVE_LO;

    onehot_t dec_y;
    onehot_t ent0_y;
    logic    skid_full;
    logic    in_fire;

    assign in_ready = en && !rst && !skid_full;
    assign in_fire  = in_valid && in_ready;

    // Line k is 1 only when every code bit matches bit j of k; constants steer each mux leg.
    for (genvar k = 0; k < ONEHOT_W; k++) begin : g_line
        localparam code_t K = code_t'(k);
        logic [CODE_W-1:0] lv;
        mux_2x1 u_m0 (
            .a_i   (!K[0]),
            .b_i   (K[0]),
            .sel_i (in_code[0]),
            .y_o   (lv[0])
        );
        for (genvar j = 1; j < CODE_W; j++) begin : g_lvl
            mux_2x1 u_mj (
                .a_i   (K[j] ? 1'b0 : lv[j-1]),
                .b_i   (K[j] ? lv[j-1] : 1'b0),
                .sel_i (in_code[j]),
                .y_o   (lv[j])
            );
        end
        assign dec_y[k] = lv[CODE_W-1];
    end

`ifdef DEC_ROUNDTRIP_CHECK_EN
    localparam int DAT_W = ONEHOT_W + CODE_W;
    logic [DAT_W-1:0] buf_out;
    code_t            ent0_code;
    code_t            enc_code;
    logic             err_q, err_d;

    dec38_skid_buf #(.DAT_W(DAT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_fire_i (in_fire),
        .in_dat_i  ({in_code, dec_y}),
        .out_rdy_i (out_ready),
        .out_vld_o (out_valid),
        .out_dat_o (buf_out),
        .full_o    (skid_full)
    );

    assign {ent0_code, ent0_y} = buf_out;

    encoder83_mux u_enc (
        .onehot_i (ent0_y),
        .code_o   (enc_code)
    );

    assign err_d = err_q || (out_valid && (enc_code != ent0_code));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    dec38_skid_buf #(.DAT_W(ONEHOT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_fire_i (in_fire),
        .in_dat_i  (dec_y),
        .out_rdy_i (out_ready),
        .out_vld_o (out_valid),
        .out_dat_o (ent0_y),
        .full_o    (skid_full)
    );

    assign err = 1'b0;
`endif

    assign out_y = ent0_y ^ POL_MASK;
endmodule

// File: tb/tb_decoder38_mux_pipe.sv
// Bench for decoder38_mux_pipe: directed vector table plus random traffic against a 2-deep queue model.
module tb_decoder38_mux_pipe;
    localparam bit         ACTIVE_LOW = 1'b0;
    localparam logic [7:0] MASK       = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam int         NVEC       = 34;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0] in_code;
    logic [7:0] out_y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mq[$];

    typedef struct {
        logic       r;
        logic       e;
        logic       iv;
        logic [2:0] code;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_y;
    } vec_t;

    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    decoder38_mux_pipe #(.ACTIVE_LOW(ACTIVE_LOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .err       (err)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic tv(input int i, input logic r, input logic e, input logic iv, input logic [2:0] code,
                      input logic ordy, input logic ir, input logic ov, input logic [7:0] y);
        tbl[i].r      = r;
        tbl[i].e      = e;
        tbl[i].iv     = iv;
        tbl[i].code   = code;
        tbl[i].ordy   = ordy;
        tbl[i].exp_ir = ir;
        tbl[i].exp_ov = ov;
        tbl[i].exp_y  = y;
    endtask

    // Drive inputs, then compare the DUT with the queue model mid-cycle.
    task automatic step_pre(input logic r, input logic e, input logic iv, input logic [2:0] code, input logic ordy);
        logic       m_ir;
        logic       m_ov;
        logic [7:0] m_y;
        rst       = r;
        en        = e;
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        @(negedge clk);
        m_ir = e && !r && (mq.size() < 2);
        m_ov = (mq.size() > 0);
        m_y  = (m_ov ? mq[0] : 8'h00) ^ MASK;
        chk("model_in_ready", in_ready, m_ir);
        chk("model_out_valid", out_valid, m_ov);
        chk("model_out_y", out_y, m_y);
        chk("err", err, 1'b0);
    endtask

    // Advance the model across the coming edge, then move past it.
    task automatic step_post();
        logic       m_ir;
        logic       pop;
        logic [7:0] word;
        m_ir = en && !rst && (mq.size() < 2);
        pop  = (mq.size() > 0) && out_ready;
        if (rst) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (in_valid && m_ir) begin
                word = 8'd1 << in_code;
                mq.push_back(word);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'd5;
        out_ready = 1'b1;

        tv(0, 1, 1, 1, 3'd5, 1, 0, 0, 8'h00);
        tv(1, 1, 1, 1, 3'd5, 1, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            tv(2 + k, 0, 1, 1, 3'(k), 1, 1, (k != 0), (k == 0) ? 8'h00 : (8'd1 << (k - 1)));
        end
        tv(10, 0, 1, 0, 3'd0, 1, 1, 1, 8'h80);
        tv(11, 0, 1, 0, 3'd0, 1, 1, 0, 8'h00);
        tv(12, 0, 1, 1, 3'd3, 0, 1, 0, 8'h00);
        tv(13, 0, 1, 1, 3'd5, 0, 1, 1, 8'h08);
        tv(14, 0, 1, 1, 3'd6, 0, 0, 1, 8'h08);
        tv(15, 0, 1, 1, 3'd6, 0, 0, 1, 8'h08);
        tv(16, 0, 1, 1, 3'd6, 1, 0, 1, 8'h08);
        tv(17, 0, 1, 1, 3'd6, 1, 1, 1, 8'h20);
        tv(18, 0, 1, 0, 3'd0, 1, 1, 1, 8'h40);
        tv(19, 0, 1, 0, 3'd0, 1, 1, 0, 8'h00);
        for (int k = 20; k < 24; k++) begin
            tv(k, 0, 0, 1, 3'd7, 1, 0, 0, 8'h00);
        end
        tv(24, 0, 1, 1, 3'd7, 1, 1, 0, 8'h00);
        tv(25, 0, 1, 0, 3'd0, 1, 1, 1, 8'h80);
        tv(26, 0, 1, 0, 3'd0, 1, 1, 0, 8'h00);
        tv(27, 0, 1, 1, 3'd1, 0, 1, 0, 8'h00);
        tv(28, 0, 1, 1, 3'd2, 0, 1, 1, 8'h02);
        tv(29, 0, 1, 0, 3'd0, 0, 0, 1, 8'h02);
        tv(30, 1, 1, 0, 3'd0, 0, 0, 1, 8'h02);
        tv(31, 0, 1, 1, 3'd4, 0, 1, 0, 8'h00);
        tv(32, 0, 1, 0, 3'd0, 1, 1, 1, 8'h10);
        tv(33, 0, 1, 0, 3'd0, 1, 1, 0, 8'h00);

        @(posedge clk);
        #1;
        mq.delete();

        for (int i = 0; i < NVEC; i++) begin
            step_pre(tbl[i].r, tbl[i].e, tbl[i].iv, tbl[i].code, tbl[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].exp_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("vec%0d_out_y", i), out_y, tbl[i].exp_y ^ MASK);
            step_post();
        end

        // Random traffic; consumer readiness bias changes per block to visit every fill level.
        for (int blk = 0; blk < 15; blk++) begin
            int bias;
            bias = $urandom_range(3);
            for (int n = 0; n < 100; n++) begin
                step_pre(($urandom_range(63) == 0),
                         ($urandom_range(7) != 0),
                         1'($urandom_range(1)),
                         3'($urandom_range(7)),
                         ($urandom_range(3) >= bias));
                step_post();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
